// File: rtl/iq_window_integrator_if.sv
// Bundles the I/Q integrator's control, sample and result signals behind one port.
// The upstream/test side uses master and the integrator uses slave.
interface iq_window_integrator_if #(
   parameter int LANES = 5,
   parameter int DW    = 16,
   parameter int LEN_W = 11,
   parameter int ACC_W = 32
);
   logic                    start;
   logic [LEN_W-1:0]        sample_length;
   logic [LANES-1:0]        lane_valid;
   logic [LANES*DW-1:0]     data_i_rot;
   logic [LANES*DW-1:0]     data_q_rot;
   logic                    out_ready;
   logic                    iq_valid;
   logic signed [ACC_W-1:0] i_val;
   logic signed [ACC_W-1:0] q_val;
   logic                    overflow;
   logic                    busy;
   logic                    missed_start;

   modport master (
      output start, sample_length, lane_valid, data_i_rot, data_q_rot, out_ready,
      input  iq_valid, i_val, q_val, overflow, busy, missed_start
   );

   modport slave (
      input  start, sample_length, lane_valid, data_i_rot, data_q_rot, out_ready,
      output iq_valid, i_val, q_val, overflow, busy, missed_start
   );
endinterface

// File: rtl/iq_window_integrator.sv
// Saturating multi-lane I/Q window integrator: result valid sample_length+1 edges after start.
// Result is held in HOLD until out_ready; starts arriving while busy are dropped and flagged.
module iq_window_integrator #(
   parameter int LANES = 5,
   parameter int DW    = 16,
   parameter int LEN_W = 11,
   parameter int ACC_W = 32
) (
   input  logic                   clk100,
   input  logic                   reset_n,
   iq_window_integrator_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, INTEGRATE, HOLD} state_t;

   state_t             state, state_nxt;
   logic [LEN_W-1:0]   len_q, cnt_q;
   logic [ACC_W-1:0]   acc_i, acc_q;
   logic               ovf_acc;
   logic [ACC_W-1:0]   i_out, q_out;
   logic               ovf_out;
   logic               missed_q;
   logic [ACC_W:0]     sum_i, sum_q;
   logic [ACC_W:0]     nxt_i, nxt_q;

   // Returns {clamped, value}; the add is one bit wider so the sign of the true sum survives.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W:0] s);
      logic [ACC_W:0] t;
      t = {a[ACC_W-1], a} + s;
      if (t[ACC_W] != t[ACC_W-1])
         return {1'b1, t[ACC_W], {(ACC_W-1){~t[ACC_W]}}};
      return {1'b0, t[ACC_W-1:0]};
   endfunction

   always_comb begin
      sum_i = '0;
      sum_q = '0;
      for (int k = 0; k < LANES; k++) begin
         if (bus.lane_valid[k]) begin
            sum_i = sum_i + {{(ACC_W+1-DW){bus.data_i_rot[k*DW+DW-1]}}, bus.data_i_rot[k*DW +: DW]};
            sum_q = sum_q + {{(ACC_W+1-DW){bus.data_q_rot[k*DW+DW-1]}}, bus.data_q_rot[k*DW +: DW]};
         end
      end
      nxt_i = sat_add(acc_i, sum_i);
      nxt_q = sat_add(acc_q, sum_q);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.start)
               state_nxt = (bus.sample_length == '0) ? HOLD : INTEGRATE;
         end
         INTEGRATE: begin
            if (cnt_q == len_q - LEN_W'(1))
               state_nxt = HOLD;
         end
         HOLD: begin
            if (bus.out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk100 or negedge reset_n) begin
      if (!reset_n) begin
         len_q    <= '0;
         cnt_q    <= '0;
         acc_i    <= '0;
         acc_q    <= '0;
         ovf_acc  <= 1'b0;
         i_out    <= '0;
         q_out    <= '0;
         ovf_out  <= 1'b0;
         missed_q <= 1'b0;
      end else begin
         missed_q <= bus.start && (state != IDLE);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  len_q   <= bus.sample_length;
                  cnt_q   <= '0;
                  acc_i   <= '0;
                  acc_q   <= '0;
                  ovf_acc <= 1'b0;
                  // A zero-length window goes straight to HOLD with an empty result.
                  if (bus.sample_length == '0) begin
                     i_out   <= '0;
                     q_out   <= '0;
                     ovf_out <= 1'b0;
                  end
               end
            end
            INTEGRATE: begin
               acc_i   <= nxt_i[ACC_W-1:0];
               acc_q   <= nxt_q[ACC_W-1:0];
               ovf_acc <= ovf_acc | nxt_i[ACC_W] | nxt_q[ACC_W];
               cnt_q   <= cnt_q + LEN_W'(1);
               if (state_nxt == HOLD) begin
                  i_out   <= nxt_i[ACC_W-1:0];
                  q_out   <= nxt_q[ACC_W-1:0];
                  ovf_out <= ovf_acc | nxt_i[ACC_W] | nxt_q[ACC_W];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.iq_valid     = (state == HOLD);
   assign bus.busy         = (state != IDLE);
   assign bus.i_val        = i_out;
   assign bus.q_val        = q_out;
   assign bus.overflow     = ovf_out;
   assign bus.missed_start = missed_q;
endmodule

// File: tb/tb_iq_window_integrator.sv
// Randomized bench for iq_window_integrator: a 32-bit and a 20-bit accumulator instance share
// one stimulus stream and are compared against a queue-based window model.
module tb_iq_window_integrator;
   localparam int LANES = 5;
   localparam int DW    = 16;
   localparam int LEN_W = 11;
   localparam int ACC_A = 32;
   localparam int ACC_B = 20;

   logic clk100 = 1'b0;
   logic reset_n;
   always #5 clk100 = ~clk100;

   iq_window_integrator_if #(.LANES(LANES), .DW(DW), .LEN_W(LEN_W), .ACC_W(ACC_A)) bus_a();
   iq_window_integrator_if #(.LANES(LANES), .DW(DW), .LEN_W(LEN_W), .ACC_W(ACC_B)) bus_b();

   assign bus_b.start         = bus_a.start;
   assign bus_b.sample_length = bus_a.sample_length;
   assign bus_b.lane_valid    = bus_a.lane_valid;
   assign bus_b.data_i_rot    = bus_a.data_i_rot;
   assign bus_b.data_q_rot    = bus_a.data_q_rot;
   assign bus_b.out_ready     = bus_a.out_ready;

   iq_window_integrator #(.LANES(LANES), .DW(DW), .LEN_W(LEN_W), .ACC_W(ACC_A)) dut_a (
      .clk100  (clk100),
      .reset_n (reset_n),
      .bus     (bus_a)
   );

   iq_window_integrator #(.LANES(LANES), .DW(DW), .LEN_W(LEN_W), .ACC_W(ACC_B)) dut_b (
      .clk100  (clk100),
      .reset_n (reset_n),
      .bus     (bus_b)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [LANES*DW-1:0] win_i[$];
   logic [LANES*DW-1:0] win_q[$];
   logic [LANES-1:0]    win_m[$];

   longint obs_ai, obs_aq, obs_bi, obs_bq;
   bit     obs_aovf, obs_bovf;

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [LANES*DW-1:0] rand_vec();
      logic [LANES*DW-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*DW +: DW] = DW'($urandom);
      return v;
   endfunction

   function automatic logic [LANES*DW-1:0] const_vec(input int val);
      logic [LANES*DW-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*DW +: DW] = DW'(val);
      return v;
   endfunction

   // Reference: per cycle, sum the enabled lanes, add to the running total, clamp to the
   // accumulator range and remember whether any clamp happened.
   function automatic longint model_sum(input bit use_q, input int accw, output bit ovf);
      longint hi, lo, acc, cyc;
      logic [LANES*DW-1:0] vec;
      logic [LANES-1:0]    msk;
      logic signed [DW-1:0] s;
      hi  = (longint'(1) <<< (accw - 1)) - 1;
      lo  = -hi - 1;
      acc = 0;
      ovf = 1'b0;
      for (int n = 0; n < win_i.size(); n++) begin
         vec = use_q ? win_q[n] : win_i[n];
         msk = win_m[n];
         cyc = 0;
         for (int k = 0; k < LANES; k++) begin
            s = vec[k*DW +: DW];
            if (msk[k]) cyc += longint'(s);
         end
         acc += cyc;
         if (acc > hi) begin acc = hi; ovf = 1'b1; end
         else if (acc < lo) begin acc = lo; ovf = 1'b1; end
      end
      return acc;
   endfunction

   task automatic drive_garbage();
      bus_a.data_i_rot = rand_vec();
      bus_a.data_q_rot = rand_vec();
      bus_a.lane_valid = LANES'($urandom);
   endtask

   task automatic clear_win();
      win_i.delete();
      win_q.delete();
      win_m.delete();
   endtask

   task automatic fill_const(input int len, input logic [LANES-1:0] msk, input int iv, input int qv);
      clear_win();
      for (int n = 0; n < len; n++) begin
         win_i.push_back(const_vec(iv));
         win_q.push_back(const_vec(qv));
         win_m.push_back(msk);
      end
   endtask

   task automatic fill_random(input int len, input bit big);
      logic [LANES*DW-1:0] vi, vq;
      bit neg;
      int mag;
      clear_win();
      neg = 1'($urandom);
      for (int n = 0; n < len; n++) begin
         if (big) begin
            for (int k = 0; k < LANES; k++) begin
               mag = int'($urandom_range(32767, 20000));
               vi[k*DW +: DW] = DW'(neg ? -mag : mag);
               vq[k*DW +: DW] = DW'(neg ? mag : -mag);
            end
         end else begin
            vi = rand_vec();
            vq = rand_vec();
         end
         win_i.push_back(vi);
         win_q.push_back(vq);
         win_m.push_back(big ? {LANES{1'b1}} : LANES'($urandom));
      end
   endtask

   // Called and returns at the negedge phase. Runs one window over the queued data, holds the
   // result for 'hold' cycles with out_ready low (optionally poking start), then completes it.
   task automatic run_window(input int hold, input bit poke, input string tag);
      int len, edges;
      bit got, sampled, t1, t2;
      longint ei_a, eq_a, ei_b, eq_b;
      bit eo_a, eo_b;
      len  = win_i.size();
      ei_a = model_sum(1'b0, ACC_A, t1);
      eq_a = model_sum(1'b1, ACC_A, t2);
      eo_a = t1 | t2;
      ei_b = model_sum(1'b0, ACC_B, t1);
      eq_b = model_sum(1'b1, ACC_B, t2);
      eo_b = t1 | t2;

      bus_a.start         = 1'b1;
      bus_a.sample_length = LEN_W'(len);
      bus_a.out_ready     = (hold == 0);
      drive_garbage();
      edges = 0;
      got   = 1'b0;
      while (!got && edges < len + 8) begin
         @(posedge clk100);
         edges++;
         #1;
         bus_a.start         = 1'b0;
         bus_a.sample_length = LEN_W'($urandom);
         if (edges <= len) begin
            bus_a.data_i_rot = win_i[edges-1];
            bus_a.data_q_rot = win_q[edges-1];
            bus_a.lane_valid = win_m[edges-1];
         end else begin
            drive_garbage();
         end
         @(negedge clk100);
         if (edges == 1) check_val({tag, "_busy"}, bus_a.busy, 1);
         got = bus_a.iq_valid;
      end
      check_val({tag, "_latency"}, edges, len + 1);
      check_val({tag, "_b_valid"}, bus_b.iq_valid, 1);
      obs_ai   = bus_a.i_val;
      obs_aq   = bus_a.q_val;
      obs_bi   = bus_b.i_val;
      obs_bq   = bus_b.q_val;
      obs_aovf = bus_a.overflow;
      obs_bovf = bus_b.overflow;
      check_val({tag, "_a_i"}, obs_ai, ei_a);
      check_val({tag, "_a_q"}, obs_aq, eq_a);
      check_val({tag, "_a_ovf"}, obs_aovf, eo_a);
      check_val({tag, "_b_i"}, obs_bi, ei_b);
      check_val({tag, "_b_q"}, obs_bq, eq_b);
      check_val({tag, "_b_ovf"}, obs_bovf, eo_b);

      for (int h = 0; h < hold; h++) begin
         @(posedge clk100);
         sampled = bus_a.start;
         #1;
         bus_a.start = poke && (h == 1);
         drive_garbage();
         @(negedge clk100);
         check_val({tag, "_hold_valid"}, bus_a.iq_valid, 1);
         check_val({tag, "_hold_i"}, bus_a.i_val, obs_ai);
         check_val({tag, "_hold_bq"}, bus_b.q_val, obs_bq);
         check_val({tag, "_hold_missed"}, bus_a.missed_start, sampled);
      end
      bus_a.out_ready = 1'b1;
      @(posedge clk100);
      sampled = bus_a.start;
      #1;
      bus_a.start = 1'b0;
      @(negedge clk100);
      check_val({tag, "_done_valid"}, bus_a.iq_valid, 0);
      check_val({tag, "_done_busy"}, bus_b.busy, 0);
      check_val({tag, "_done_missed"}, bus_a.missed_start, sampled);
   endtask

   initial begin
      logic [LANES*DW-1:0] mixed;
      int vcount;
      reset_n             = 1'b0;
      bus_a.start         = 1'b0;
      bus_a.sample_length = '0;
      bus_a.lane_valid    = '0;
      bus_a.data_i_rot    = '0;
      bus_a.data_q_rot    = '0;
      bus_a.out_ready     = 1'b1;
      repeat (2) @(negedge clk100);
      check_val("rst_valid", bus_a.iq_valid, 0);
      check_val("rst_i", bus_a.i_val, 0);
      check_val("rst_q", bus_a.q_val, 0);
      check_val("rst_ovf", bus_a.overflow, 0);
      check_val("rst_busy", bus_a.busy, 0);
      check_val("rst_missed", bus_a.missed_start, 0);
      check_val("rst_b_i", bus_b.i_val, 0);
      reset_n = 1'b1;

      fill_const(4, {LANES{1'b1}}, 3, -2);
      run_window(0, 1'b0, "basic");
      check_val("basic_i_60", obs_ai, 60);
      check_val("basic_q_m40", obs_aq, -40);
      check_val("basic_ovf", obs_aovf, 0);

      fill_const(10, 5'b00101, 3, -2);
      run_window(1, 1'b0, "mask");
      check_val("mask_i_60", obs_ai, 60);
      check_val("mask_q_m40", obs_aq, -40);

      clear_win();
      mixed = '0;
      mixed[0*DW +: DW] = 16'sd100;
      mixed[1*DW +: DW] = -16'sd100;
      mixed[2*DW +: DW] = 16'sd7;
      win_i.push_back(mixed);
      win_q.push_back(rand_vec());
      win_m.push_back({LANES{1'b1}});
      run_window(0, 1'b0, "mixed");
      check_val("mixed_i_7", obs_ai, 7);

      fill_const(8, {LANES{1'b1}}, 32767, 0);
      run_window(0, 1'b0, "satpos");
      check_val("satpos_b_i", obs_bi, 524287);
      check_val("satpos_b_ovf", obs_bovf, 1);
      check_val("satpos_a_i", obs_ai, 1310680);
      check_val("satpos_a_ovf", obs_aovf, 0);

      fill_const(8, {LANES{1'b1}}, -32768, 0);
      run_window(0, 1'b0, "satneg");
      check_val("satneg_b_i", obs_bi, -524288);
      check_val("satneg_b_ovf", obs_bovf, 1);

      fill_const(0, {LANES{1'b1}}, 0, 0);
      run_window(0, 1'b0, "len0");
      check_val("len0_b_i", obs_bi, 0);
      check_val("len0_b_ovf", obs_bovf, 0);

      fill_const(3, {LANES{1'b1}}, 1, 1);
      run_window(6, 1'b1, "bp");
      fill_random(5, 1'b0);
      run_window(0, 1'b0, "after_bp");

      fill_const(2047, {LANES{1'b1}}, 1, 0);
      run_window(0, 1'b0, "len2047");
      check_val("len2047_i", obs_ai, 10235);

      fill_random(10, 1'b0);
      bus_a.start         = 1'b1;
      bus_a.sample_length = LEN_W'(10);
      @(posedge clk100);
      #1;
      bus_a.start = 1'b0;
      for (int n = 0; n < 3; n++) begin
         bus_a.data_i_rot = win_i[n];
         bus_a.data_q_rot = win_q[n];
         bus_a.lane_valid = win_m[n];
         @(posedge clk100);
         #1;
      end
      @(negedge clk100);
      #1;
      reset_n = 1'b0;
      #1;
      check_val("midrst_valid", bus_a.iq_valid, 0);
      check_val("midrst_busy", bus_a.busy, 0);
      check_val("midrst_i", bus_a.i_val, 0);
      check_val("midrst_q", bus_a.q_val, 0);
      check_val("midrst_ovf", bus_a.overflow, 0);
      check_val("midrst_b_i", bus_b.i_val, 0);
      @(posedge clk100);
      @(negedge clk100);
      reset_n = 1'b1;
      vcount = 0;
      for (int n = 0; n < 14; n++) begin
         @(negedge clk100);
         if (bus_a.iq_valid || bus_b.iq_valid) vcount++;
      end
      check_val("midrst_no_result", vcount, 0);
      fill_random(6, 1'b0);
      run_window(0, 1'b0, "post_rst");

      for (int w = 0; w < 30; w++) begin
         int hold;
         hold = int'($urandom_range(0, 4));
         fill_random((w % 7 == 0) ? 0 : int'($urandom_range(1, 24)), (w % 3 == 1));
         run_window(hold, (hold >= 3) && 1'($urandom), $sformatf("rnd%0d", w));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
